// File: rtl/serial_link_arbiter.sv
// serial_link_arbiter: round-robin arbiter that serializes the granted word as a start pulse, then ID bits, then data bits, each LSB first
// Ports: clk, rst (sync, active-high); req_valid/req_data in from NUM_REQ requesters;
//        req_ready one-hot accept strobe; serial_out/start/grant_id registered frame outputs; busy while a frame is in flight
module serial_link_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       serial_out,
  output logic                       start,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(WIDTH + IDW + 1);
  typedef enum logic [1:0] {IDLE, START_PULSE, SEND_ID, SEND_DATA} state_t;
  state_t r_state, w_next;
  logic [IDW-1:0] r_ptr, r_gid, w_sel, w_idx, w_idsh;
  logic [WIDTH-1:0] r_shadow, w_dsh;
  logic [CW-1:0] r_cnt, w_nxt;
  logic r_ser, r_start, w_found, w_hs, w_last_id, w_last_d;
  // Scan offsets high to low so the nearest valid requester at or after r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = r_ptr + IDW'(k);
      if (req_valid[w_idx]) begin
        w_found = 1'b1;
        w_sel = w_idx;
      end
    end
  end
  assign w_hs      = r_state == IDLE && w_found;
  assign w_nxt     = r_cnt + CW'(1);
  assign w_idsh    = r_gid >> w_nxt;
  assign w_dsh     = r_shadow >> w_nxt;
  assign w_last_id = r_cnt == CW'(IDW - 1);
  assign w_last_d  = r_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:        w_next = w_hs ? START_PULSE : IDLE;
      START_PULSE: w_next = SEND_ID;
      SEND_ID:     w_next = w_last_id ? SEND_DATA : SEND_ID;
      SEND_DATA:   w_next = w_last_d ? IDLE : SEND_DATA;
      default:     w_next = IDLE;
    endcase
  end
  always_comb begin
    req_ready = (!rst && w_hs) ? (NUM_REQ'(1) << w_sel) : '0;
    busy      = !rst && r_state != IDLE;
  end
  // Each cycle loads the bit that the next cycle presents on serial_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_gid    <= '0;
      r_shadow <= '0;
      r_ser    <= 1'b0;
      r_start  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ser <= 1'b0;
          if (w_hs) begin
            r_shadow <= req_data[w_sel*WIDTH +: WIDTH];
            r_gid    <= w_sel;
            r_ptr    <= w_sel + IDW'(1);
            r_start  <= 1'b1;
          end
        end
        START_PULSE: begin
          r_start <= 1'b0;
          r_ser   <= r_gid[0];
          r_cnt   <= '0;
        end
        SEND_ID: begin
          r_ser <= w_last_id ? r_shadow[0] : w_idsh[0];
          r_cnt <= w_last_id ? '0 : w_nxt;
        end
        SEND_DATA: begin
          r_ser <= w_last_d ? 1'b0 : w_dsh[0];
          r_cnt <= w_last_d ? '0 : w_nxt;
        end
        default: begin
          r_start <= 1'b0;
          r_ser   <= 1'b0;
        end
      endcase
    end
  end
  assign serial_out = r_ser;
  assign start      = r_start;
  assign grant_id   = r_gid;
endmodule

// File: tb/tb_serial_link_arbiter.sv
// tb_serial_link_arbiter: table-driven grant vectors plus a frame scoreboard for serial_link_arbiter
module tb_serial_link_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic serial_out, start, busy;
  logic [1:0] grant_id;
  serial_link_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .serial_out(serial_out), .start(start),
    .grant_id(grant_id), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {logic rst_b; logic [3:0] valid; logic [31:0] data; int exp;} vec_t;
  typedef struct {int id; logic [7:0] d; int cyc;} exp_t;
  vec_t tv[14];
  exp_t q[$];
  exp_t e;
  int checks = 0, fails = 0, cyc = 0;
  logic inv_en = 1'b0, prev_start = 1'b0, ab;
  logic [9:0] fr;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int id, input logic [7:0] d);
    q.push_back('{id, d, cyc + 1});
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    step();
    @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_serial", serial_out, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy2", busy, 0);
    step();
    rst = 1'b0;
    req_valid = '0;
  endtask
  always @(negedge clk) if (inv_en) begin
    chk("inv_onehot0", $onehot0(req_ready), 1);
    chk("inv_ready_busy", |req_ready && busy, 0);
    chk("inv_start_twice", start && prev_start, 0);
    prev_start = start;
  end
  initial forever begin
    @(negedge clk);
    if (start && !rst) begin
      chk("sb_nonempty", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("start_cycle", cyc, e.cyc);
        chk("grant_id", grant_id, e.id);
        chk("ser_at_start", serial_out, 0);
        ab = 1'b0;
        for (int b = 0; b < 10; b++) begin
          @(negedge clk);
          if (rst) begin
            ab = 1'b1;
            break;
          end
          fr[b] = serial_out;
        end
        if (!ab) begin
          chk("frame", fr, {e.d, 2'(e.id)});
          @(negedge clk);
          chk("ser_idle", serial_out, 0);
        end
      end
    end
  end
  initial begin
    tv[0]  = '{1'b1, 4'b0001, 32'h000000A5, 0};
    tv[1]  = '{1'b1, 4'b1111, 32'h44332211, 0};
    tv[2]  = '{1'b0, 4'b1111, 32'h44332211, 1};
    tv[3]  = '{1'b0, 4'b1111, 32'h44332211, 2};
    tv[4]  = '{1'b0, 4'b1111, 32'h44332211, 3};
    tv[5]  = '{1'b0, 4'b1111, 32'h44332211, 0};
    tv[6]  = '{1'b1, 4'b0100, 32'h00C30000, 2};
    tv[7]  = '{1'b0, 4'b0101, 32'h00C3007E, 0};
    tv[8]  = '{1'b0, 4'b0101, 32'h00C3007E, 2};
    tv[9]  = '{1'b0, 4'b1010, 32'h9B00E100, 3};
    tv[10] = '{1'b0, 4'b1010, 32'h9B00E100, 1};
    tv[11] = '{1'b0, 4'b0011, 32'h00005C81, 0};
    tv[12] = '{1'b0, 4'b0011, 32'h00005C81, 1};
    tv[13] = '{1'b0, 4'b1001, 32'hF00000F0, 3};
    do_reset();
    inv_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (tv[i].rst_b) do_reset();
      req_valid = tv[i].valid;
      req_data = tv[i].data;
      @(negedge clk);
      chk($sformatf("ready_v%0d", i), req_ready, 32'(1) << tv[i].exp);
      push(tv[i].exp, tv[i].data[tv[i].exp*8 +: 8]);
      repeat (12) step();
      chk($sformatf("busy_end_v%0d", i), busy, 0);
    end
    req_valid = 4'b0001;
    req_data = 32'h0;
    @(negedge clk);
    chk("ready_shadow", req_ready, 4'b0001);
    push(0, 8'h00);
    step();
    req_valid = '0;
    req_data = '1;
    repeat (11) step();
    chk("busy_end_shadow", busy, 0);
    req_valid = 4'b0010;
    req_data = 32'h00005A00;
    @(negedge clk);
    chk("ready_abort", req_ready, 4'b0010);
    push(1, 8'h5A);
    step();
    req_valid = '0;
    repeat (7) step();
    rst = 1'b1;
    req_valid = 4'b0110;
    req_data = 32'h003C3C00;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_serial", serial_out, 0);
    chk("post_rst_start", start, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", req_ready, 4'b0010);
    push(1, 8'h3C);
    step();
    req_valid = '0;
    repeat (11) step();
    chk("busy_end_post", busy, 0);
    repeat (3) step();
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
